// File: rtl/data_block_memory.sv
`default_nettype none
// ============================================================================
//  Module      : data_block_memory
//  Description : Block-granular main-memory responder behind the data cache.
//                A read or write request is accepted in IDLE, the requester
//                is stalled through mem_busywait for LATENCY+1 cycles, and
//                then the transfer completes. A single DONE cycle follows,
//                with busywait low, before the next request is accepted.
//  Ports       : CLOCK, RESET (async, active-high)
//                mem_read / mem_write      level requests (write wins)
//                mem_address / mem_writedata  block address and write data
//                mem_readdata              last completed read block
//                mem_busywait              stall towards the requester
//                mem_parity_err            only with DATA_MEM_PARITY_EN:
//                                          byte-parity error of last read
//  Options     : DATA_MEM_PARITY_EN adds per-byte even parity storage.
//  Revision    : 1.0  initial release
// ============================================================================
module data_block_memory #(
    parameter int ADDR_W  = 6,
    parameter int BLOCK_W = 32,
    parameter int LATENCY = 5
) (
    input  logic               CLOCK,
    input  logic               RESET,
    input  logic               mem_read,
    input  logic               mem_write,
    input  logic [ADDR_W-1:0]  mem_address,
    input  logic [BLOCK_W-1:0] mem_writedata,
    output logic [BLOCK_W-1:0] mem_readdata,
    output logic               mem_busywait
`ifdef DATA_MEM_PARITY_EN
    ,
    output logic               mem_parity_err
`endif
);

    localparam int         c_DEPTH    = 2 ** ADDR_W;
    localparam logic [3:0] c_CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic                 wr_q, wr_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [BLOCK_W-1:0]   wdata_q, wdata_d;
    logic [BLOCK_W-1:0]   rdata_q;
    logic [BLOCK_W-1:0]   mem_q [c_DEPTH];
    logic                 w_finish;

    // Completion edge: last BUSY cycle with the counter exhausted.
    assign w_finish = (state_q == S_BUSY) && (cnt_q == 4'd0);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        wr_d         = wr_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        mem_busywait = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Combinational stall so the requester sees it in the
                // same cycle it raises the request.
                mem_busywait = mem_read | mem_write;
                if (mem_read || mem_write) begin
                    state_d = S_BUSY;
                    cnt_d   = c_CNT_INIT;
                    wr_d    = mem_write;     // write has priority over read
                    addr_d  = mem_address;
                    wdata_d = mem_writedata;
                end
            end
            S_BUSY: begin
                mem_busywait = 1'b1;
                if (cnt_q == 4'd0) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // While reset is held the stall must read low even if a request
        // is still presented in IDLE.
        if (RESET) begin
            mem_busywait = 1'b0;
        end
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            if (w_finish && !wr_q) begin
                rdata_q <= mem_q[addr_q];
            end
        end
    end

    // Storage is never cleared. A reset forces state_q to IDLE, so an
    // in-flight write can never reach its commit edge.
    always_ff @(posedge CLOCK) begin
        if (w_finish && wr_q) begin
            mem_q[addr_q] <= wdata_q;
        end
    end

    assign mem_readdata = rdata_q;

`ifdef DATA_MEM_PARITY_EN
    localparam int c_NBYTES = BLOCK_W / 8;

    logic [c_NBYTES-1:0] par_q [c_DEPTH];
    logic                perr_q;

    // Even parity: stored bit makes each byte plus its bit XOR to zero.
    function automatic logic [c_NBYTES-1:0] f_parity(input logic [BLOCK_W-1:0] d);
        logic [c_NBYTES-1:0] p;
        for (int i = 0; i < c_NBYTES; i++) begin
            p[i] = ^d[i*8 +: 8];
        end
        return p;
    endfunction

    always_ff @(posedge CLOCK) begin
        if (w_finish && wr_q) begin
            par_q[addr_q] <= f_parity(wdata_q);
        end
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            perr_q <= 1'b0;
        end else if (w_finish && !wr_q) begin
            perr_q <= |(f_parity(mem_q[addr_q]) ^ par_q[addr_q]);
        end
    end

    assign mem_parity_err = perr_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_data_block_memory.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_block_memory
//  Description : Directed self-checking bench for data_block_memory
//                (default parameters, LATENCY = 5).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_data_block_memory;

    localparam int LAT = 5;

    logic        CLOCK;
    logic        RESET;
    logic        mem_read;
    logic        mem_write;
    logic [5:0]  mem_address;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic        mem_busywait;
`ifdef DATA_MEM_PARITY_EN
    logic        mem_parity_err;
`endif

    int n_total = 0;
    int n_pass  = 0;
    int ncyc;

    data_block_memory #(
        .ADDR_W (6),
        .BLOCK_W(32),
        .LATENCY(LAT)
    ) dut (
        .CLOCK        (CLOCK),
        .RESET        (RESET),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_address  (mem_address),
        .mem_writedata(mem_writedata),
        .mem_readdata (mem_readdata),
        .mem_busywait (mem_busywait)
`ifdef DATA_MEM_PARITY_EN
        ,
        .mem_parity_err(mem_parity_err)
`endif
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Presents a request at a negedge and counts negedge samples with
    // busywait high; returns just after the first low sample (DONE).
    task automatic access(input logic rd, input logic wr, input logic [5:0] a,
                          input logic [31:0] d, output int n);
        mem_read      = rd;
        mem_write     = wr;
        mem_address   = a;
        mem_writedata = d;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (mem_busywait) begin
                n++;
                @(negedge CLOCK);
            end else begin
                break;
            end
        end
    endtask

    // Drop the request in DONE; the next cycle must be an idle one.
    task automatic release_req(input string tag);
        mem_read  = 1'b0;
        mem_write = 1'b0;
        @(negedge CLOCK);
        #1;
        check(tag, 32'(mem_busywait), 32'd0);
    endtask

    initial begin
        RESET         = 1'b1;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_address   = '0;
        mem_writedata = '0;
        repeat (2) @(negedge CLOCK);
        #1;
        check("reset_busywait", 32'(mem_busywait), 32'd0);
        check("reset_readdata", mem_readdata, 32'd0);
        RESET = 1'b0;
        @(negedge CLOCK);

        // Write then read
        access(1'b0, 1'b1, 6'h05, 32'hDEADBEEF, ncyc);
        check("wr05_cycles", 32'(ncyc), 32'(LAT + 1));
        check("wr05_rdata_unchanged", mem_readdata, 32'd0);
        release_req("wr05_idle");
        access(1'b1, 1'b0, 6'h05, 32'h0, ncyc);
        check("rd05_cycles", 32'(ncyc), 32'(LAT + 1));
        check("rd05_data", mem_readdata, 32'hDEADBEEF);
        release_req("rd05_idle");

        // Read and write together behave as a write
        access(1'b1, 1'b1, 6'h3F, 32'h12345678, ncyc);
        check("rw3f_cycles", 32'(ncyc), 32'(LAT + 1));
        check("rw3f_rdata_unchanged", mem_readdata, 32'hDEADBEEF);
        release_req("rw3f_idle");
        access(1'b1, 1'b0, 6'h3F, 32'h0, ncyc);
        check("rd3f_data", mem_readdata, 32'h12345678);
        release_req("rd3f_idle");

        // Mid-access address change is ignored
        access(1'b0, 1'b1, 6'h01, 32'hA5A5A5A5, ncyc);
        release_req("wr01_idle");
        access(1'b0, 1'b1, 6'h02, 32'h5A5A5A5A, ncyc);
        release_req("wr02_idle");
        mem_read    = 1'b1;
        mem_address = 6'h01;
        @(negedge CLOCK);
        mem_address = 6'h02;
        ncyc = 1;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (!mem_busywait) break;
            ncyc++;
            @(negedge CLOCK);
        end
        check("midchg_cycles", 32'(ncyc), 32'(LAT + 1));
        check("midchg_data", mem_readdata, 32'hA5A5A5A5);
        release_req("midchg_idle");

        // Reset in the third BUSY cycle aborts a write
        access(1'b0, 1'b1, 6'h0A, 32'h11112222, ncyc);
        release_req("wr0a_idle");
        mem_write     = 1'b1;
        mem_address   = 6'h0A;
        mem_writedata = 32'hCAFEF00D;
        repeat (3) @(negedge CLOCK);
        RESET = 1'b1;
        #1;
        check("rst_mid_busywait", 32'(mem_busywait), 32'd0);
        check("rst_mid_readdata", mem_readdata, 32'd0);
        @(negedge CLOCK);
        mem_write = 1'b0;
        RESET     = 1'b0;
        @(negedge CLOCK);
        access(1'b1, 1'b0, 6'h0A, 32'h0, ncyc);
        check("rd0a_after_abort", mem_readdata, 32'h11112222);
        release_req("rd0a_idle");

        // Back-to-back: request held through DONE is re-accepted
        access(1'b1, 1'b0, 6'h05, 32'h0, ncyc);
        check("b2b_first_cycles", 32'(ncyc), 32'(LAT + 1));
        check("b2b_done_low", 32'(mem_busywait), 32'd0);
        @(negedge CLOCK);
        access(1'b1, 1'b0, 6'h3F, 32'h0, ncyc);
        check("b2b_second_cycles", 32'(ncyc), 32'(LAT + 1));
        check("b2b_second_data", mem_readdata, 32'h12345678);
        release_req("b2b_idle");

`ifdef DATA_MEM_PARITY_EN
        access(1'b0, 1'b1, 6'h07, 32'h00000001, ncyc);
        release_req("wr07_idle");
        dut.par_q[7][0] = ~dut.par_q[7][0];
        access(1'b1, 1'b0, 6'h07, 32'h0, ncyc);
        check("par07_data", mem_readdata, 32'h00000001);
        check("par07_err", 32'(mem_parity_err), 32'd1);
        release_req("rd07_idle");
        access(1'b1, 1'b0, 6'h05, 32'h0, ncyc);
        check("par05_err", 32'(mem_parity_err), 32'd0);
        release_req("rd05p_idle");
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/data_block_memory.md
Name: data_block_memory

Overview:
- Multi-cycle main-memory responder behind the data cache. Serves block-granular read and write requests from the cache miss/write-back logic.
- Stalls the requester with a busywait handshake for a fixed latency, then completes the transfer.
- It is the responder end of the cache's memory-side read/write/busywait interface.

Parameters:
- ADDR_W, 6, block address width (DEPTH = 2**ADDR_W blocks).
- BLOCK_W, 32, block width in bits (4 bytes).
- LATENCY, 5, cycles from request acceptance to completion; legal range 1..15.

Ports:
- CLOCK  input  1  system clock, rising edge.
- RESET  input  1  asynchronous, active-high reset.
- mem_read  input  1  read request, level, held until busywait falls.
- mem_write  input  1  write request, level, held until busywait falls.
- mem_address  input  ADDR_W  block address.
- mem_writedata  input  BLOCK_W  write block data.
- mem_readdata  output  BLOCK_W  read block data.
- mem_busywait  output  1  high while request pending/in service.

Behaviour:
- Reset (RESET=1, asynchronous):
  - state=IDLE, counter=0, mem_readdata=0, mem_busywait=0.
  - Array contents are NOT cleared.
  - Reset mid-operation aborts the access: a pending write is not committed; a pending read does not update readdata.
- States: IDLE, BUSY, DONE.
- IDLE:
  - mem_busywait = mem_read | mem_write, combinational, so the requester sees the stall in the request cycle.
  - On a rising edge with a request: latch op, address and writedata; counter = LATENCY-1; go to BUSY.
- BUSY:
  - mem_busywait=1. Counter decrements each edge.
  - On the edge where counter==0:
    - read: mem_readdata <= array[addr_latched].
    - write: array[addr_latched] <= data_latched.
    - Go to DONE.
  - Total busywait-high cycles = LATENCY+1, including the request cycle.
- DONE:
  - mem_busywait=0 for exactly one cycle. Requester must drop the request this cycle; inputs are ignored.
  - Next edge goes to IDLE.
  - A request still held in DONE is re-accepted in IDLE as a new access.
- Request inputs in BUSY are ignored. Latched values govern; address/data changes mid-access have no effect.
- mem_read and mem_write together: write has priority; treated as a write only.
- mem_readdata holds its last value until the next completed read; writes do not change it.
- LATENCY=1: BUSY lasts one edge (counter starts at 0).
- Address wrap: none; mem_address indexes 0..DEPTH-1 directly.

Optional Feature:
- Macro: DATA_MEM_PARITY_EN.
- When defined:
  - Each stored byte carries an even-parity bit, computed on write commit.
  - Extra output mem_parity_err (1 bit, reset 0): on read completion, set to 1 if any byte's recomputed parity mismatches its stored bit, else cleared to 0. Updated on the same edge as mem_readdata.
  - Parity bits are not cleared by reset. The bench may force a stored parity bit via hierarchical access.
- When undefined: no parity storage, no mem_parity_err port; behaviour is otherwise identical.

Test Plan:
- Write then read: write addr 6'h05, data 32'hDEADBEEF → busywait high 6 cycles (LATENCY=5), then low. Read addr 5 → mem_readdata=32'hDEADBEEF on completion edge, busywait high 6 cycles.
- Read/write conflict: mem_read=1 and mem_write=1, addr 6'h3F, data 32'h12345678 → treated as write. Subsequent read of 6'h3F returns 32'h12345678; readdata unchanged during the write.
- Mid-access input change: start read of addr 6'h01 (holds 32'hA5A5A5A5); change address to 6'h02 during BUSY → returns 32'hA5A5A5A5.
- Reset mid-write: write addr 6'h0A, data 32'hCAFEF00D; assert RESET in the 3rd BUSY cycle → busywait=0 and readdata=0 immediately. Subsequent read of 6'h0A returns the prior contents, not 32'hCAFEF00D.
- Back-to-back requests: hold mem_read through DONE → one low busywait cycle, then a new 6-cycle access. Dropping the request in DONE → IDLE with busywait=0.
- Parity (DATA_MEM_PARITY_EN): write 32'h00000001 to addr 6'h07, force byte-0 parity bit flipped, read → mem_parity_err=1. Clean read of another address → mem_parity_err=0.
